// File: rtl/vpu_wb_buffer.sv
// rtl/vpu_wb_buffer.sv - VRF write-back FIFO between the lane wrapper and the shared VRF write port
// Optional partial-write coalescing into the youngest entry is enabled by VPU_WB_COALESCE_EN.
module vpu_wb_buffer #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       result_valid_i,
  input  logic [4:0]                 result_addr_i,
  input  logic [VLEN/8-1:0]          result_bweb_i,
  input  logic [VLEN-1:0]            result_data_i,
  output logic                       ready_o,
  output logic                       vrf_we_o,
  output logic [4:0]                 vrf_addr_o,
  output logic [VLEN/8-1:0]          vrf_bweb_o,
  output logic [VLEN-1:0]            vrf_data_o,
  input  logic                       vrf_ready_i,
  input  logic [4:0]                 query_addr_i,
  output logic                       query_hit_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int BW = VLEN / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic            valid_q [DEPTH];
  logic [4:0]      addr_q  [DEPTH];
  logic [BW-1:0]   bweb_q  [DEPTH];
  logic [VLEN-1:0] data_q  [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic head_valid, pop, nz_bytes, young_match, merge_ok, push_new;

  assign head_valid = valid_q[head_q];
  assign pop        = head_valid && vrf_ready_i;
  assign nz_bytes   = |result_bweb_i;

`ifdef VPU_WB_COALESCE_EN
  logic [PW-1:0] young;
  logic          do_merge;

  assign young       = tail_q - PW'(1);
  assign young_match = (count_q != '0) && (addr_q[young] == result_addr_i);
  // A lone entry that is leaving this cycle cannot absorb the write; it gets a fresh slot.
  assign merge_ok    = young_match && !((count_q == CW'(1)) && pop);
  assign do_merge    = result_valid_i && nz_bytes && merge_ok;
`else
  assign young_match = 1'b0;
  assign merge_ok    = 1'b0;
`endif

  // The pop term of merge_ok only matters at count==1, where space exists anyway,
  // so ready_o stays independent of vrf_ready_i.
  assign ready_o  = (count_q < FULL) || young_match;
  assign push_new = result_valid_i && ready_o && nz_bytes && !merge_ok;

  assign vrf_we_o   = head_valid;
  assign vrf_addr_o = head_valid ? addr_q[head_q] : '0;
  assign vrf_bweb_o = head_valid ? bweb_q[head_q] : '0;
  assign vrf_data_o = head_valid ? data_q[head_q] : '0;

  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  always_comb begin
    query_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == query_addr_i)) query_hit_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        bweb_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (push_new) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= result_addr_i;
        bweb_q[tail_q]  <= result_bweb_i;
        data_q[tail_q]  <= result_data_i;
        tail_q          <= tail_q + PW'(1);
      end
`ifdef VPU_WB_COALESCE_EN
      if (do_merge) begin
        for (int b = 0; b < BW; b++) begin
          if (result_bweb_i[b]) data_q[young][8*b +: 8] <= result_data_i[8*b +: 8];
        end
        bweb_q[young] <= bweb_q[young] | result_bweb_i;
      end
`endif
      count_q <= count_q + CW'(push_new) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_vpu_wb_buffer.sv
// tb/tb_vpu_wb_buffer.sv - directed vector bench for vpu_wb_buffer
// Expectations follow VPU_WB_COALESCE_EN when it is defined for the build.
module tb_vpu_wb_buffer;

  localparam int VLEN  = 64;
  localparam int DEPTH = 4;
  localparam int BW    = VLEN / 8;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef VPU_WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rv;
  logic [4:0]      ra;
  logic [BW-1:0]   rbe;
  logic [VLEN-1:0] rd;
  logic            rdy;
  logic            we;
  logic [4:0]      va;
  logic [BW-1:0]   vbe;
  logic [VLEN-1:0] vd;
  logic            vr;
  logic [4:0]      qa;
  logic            hit;
  logic [CW-1:0]   cnt;
  logic            emp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vpu_wb_buffer #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .result_valid_i(rv), .result_addr_i(ra), .result_bweb_i(rbe), .result_data_i(rd),
    .ready_o(rdy),
    .vrf_we_o(we), .vrf_addr_o(va), .vrf_bweb_o(vbe), .vrf_data_o(vd), .vrf_ready_i(vr),
    .query_addr_i(qa), .query_hit_o(hit),
    .count_o(cnt), .empty_o(emp)
  );

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [7:0]  be;
    logic [63:0] d;
    logic        vr;
    logic [4:0]  qa;
    logic        rdy;
    logic        we;
    logic [4:0]  va;
    logic [7:0]  vbe;
    logic [63:0] vd;
    logic [2:0]  cnt;
    logic        emp;
    logic        hit;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [4:0] a, input logic [7:0] be, input logic [63:0] d,
                     input logic vr_in, input logic [4:0] q,
                     input logic e_rdy, input logic e_we, input logic [4:0] e_va, input logic [7:0] e_vbe,
                     input logic [63:0] e_vd, input logic [2:0] e_cnt, input logic e_emp, input logic e_hit);
    vec_t t;
    t.v = v; t.a = a; t.be = be; t.d = d; t.vr = vr_in; t.qa = q;
    t.rdy = e_rdy; t.we = e_we; t.va = e_va; t.vbe = e_vbe; t.vd = e_vd;
    t.cnt = e_cnt; t.emp = e_emp; t.hit = e_hit;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rv = 1'b0; ra = '0; rbe = '0; rd = '0;
  endtask

  initial begin
    rst_n = 1'b0; vr = 1'b0; qa = '0;
    idle_inputs();

    // Idle, single write and drain
    add(0, 0, 8'h00, 64'h0, 1, 0,  1, 0, 0, 8'h00, 64'h0, 0, 1, 0);
    add(1, 5, 8'h0F, 64'h11223344_55667788, 0, 5,  1, 0, 0, 8'h00, 64'h0, 0, 1, 0);
    add(0, 0, 8'h00, 64'h0, 1, 5,  1, 1, 5, 8'h0F, 64'h11223344_55667788, 1, 0, 1);
    add(0, 0, 8'h00, 64'h0, 1, 5,  1, 0, 0, 8'h00, 64'h0, 0, 1, 0);
    // Coalesce two partial writes to v3
    add(1, 3, 8'h03, 64'h0000_0000_0000_AAAA, 0, 3,  1, 0, 0, 8'h00, 64'h0, 0, 1, 0);
    add(1, 3, 8'h0C, 64'h0000_0000_BBBB_0000, 0, 3,  1, 1, 3, 8'h03, 64'h0000_0000_0000_AAAA, 1, 0, 1);
    add(0, 0, 8'h00, 64'h0, 0, 3,  1, 1, 3, COAL ? 8'h0F : 8'h03,
        COAL ? 64'h0000_0000_BBBB_AAAA : 64'h0000_0000_0000_AAAA, COAL ? 3'd1 : 3'd2, 0, 1);
    add(0, 0, 8'h00, 64'h0, 1, 3,  1, 1, 3, COAL ? 8'h0F : 8'h03,
        COAL ? 64'h0000_0000_BBBB_AAAA : 64'h0000_0000_0000_AAAA, COAL ? 3'd1 : 3'd2, 0, 1);
    add(0, 0, 8'h00, 64'h0, 1, 3,  1, !COAL, COAL ? 5'd0 : 5'd3, COAL ? 8'h00 : 8'h0C,
        COAL ? 64'h0 : 64'h0000_0000_BBBB_0000, COAL ? 3'd0 : 3'd1, COAL, !COAL);
    add(0, 0, 8'h00, 64'h0, 1, 3,  1, 0, 0, 8'h00, 64'h0, 0, 1, 0);
    // Fill to DEPTH, merge into youngest when full, reject new address, drain in order
    add(1, 0, 8'hFF, 64'hA0, 0, 9,  1, 0, 0, 8'h00, 64'h0,  0, 1, 0);
    add(1, 1, 8'hFF, 64'hA1, 0, 9,  1, 1, 0, 8'hFF, 64'hA0, 1, 0, 0);
    add(1, 2, 8'hFF, 64'hA2, 0, 9,  1, 1, 0, 8'hFF, 64'hA0, 2, 0, 0);
    add(1, 3, 8'hFF, 64'hA3, 0, 9,  1, 1, 0, 8'hFF, 64'hA0, 3, 0, 0);
    add(1, 3, 8'h01, 64'h33, 0, 9,  COAL, 1, 0, 8'hFF, 64'hA0, 4, 0, 0);
    add(1, 9, 8'hFF, 64'h99, 0, 9,  0, 1, 0, 8'hFF, 64'hA0, 4, 0, 0);
    add(1, 9, 8'hFF, 64'h99, 1, 9,  0, 1, 0, 8'hFF, 64'hA0, 4, 0, 0);
    add(0, 0, 8'h00, 64'h0,  1, 9,  1, 1, 1, 8'hFF, 64'hA1, 3, 0, 0);
    add(0, 0, 8'h00, 64'h0,  1, 9,  1, 1, 2, 8'hFF, 64'hA2, 2, 0, 0);
    add(0, 0, 8'h00, 64'h0,  1, 9,  1, 1, 3, 8'hFF, COAL ? 64'h33 : 64'hA3, 1, 0, 0);
    add(0, 0, 8'h00, 64'h0,  1, 9,  1, 0, 0, 8'h00, 64'h0, 0, 1, 0);
    // Pop/merge race on a single entry: second write gets its own slot
    add(1, 7, 8'hFF, 64'h71, 0, 7,  1, 0, 0, 8'h00, 64'h0,  0, 1, 0);
    add(1, 7, 8'hFF, 64'h72, 1, 7,  1, 1, 7, 8'hFF, 64'h71, 1, 0, 1);
    add(0, 0, 8'h00, 64'h0,  1, 7,  1, 1, 7, 8'hFF, 64'h72, 1, 0, 1);
    add(0, 0, 8'h00, 64'h0,  1, 7,  1, 0, 0, 8'h00, 64'h0,  0, 1, 0);
    // Query and zero-byte write
    add(1, 2, 8'hFF, 64'h22,   0, 6,  1, 0, 0, 8'h00, 64'h0,  0, 1, 0);
    add(1, 6, 8'hFF, 64'h66,   0, 6,  1, 1, 2, 8'hFF, 64'h22, 1, 0, 0);
    add(1, 6, 8'h00, 64'hFFFF, 0, 6,  1, 1, 2, 8'hFF, 64'h22, 2, 0, 1);
    add(0, 0, 8'h00, 64'h0,    0, 4,  1, 1, 2, 8'hFF, 64'h22, 2, 0, 0);
    add(0, 0, 8'h00, 64'h0,    1, 6,  1, 1, 2, 8'hFF, 64'h22, 2, 0, 1);
    add(0, 0, 8'h00, 64'h0,    1, 6,  1, 1, 6, 8'hFF, 64'h66, 1, 0, 1);
    add(0, 0, 8'h00, 64'h0,    1, 6,  1, 0, 0, 8'h00, 64'h0,  0, 1, 0);

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_ready", -1, 64'(rdy), 64'd1);
    chk("rst_we",    -1, 64'(we),  64'd0);
    chk("rst_count", -1, 64'(cnt), 64'd0);
    chk("rst_empty", -1, 64'(emp), 64'd1);
    chk("rst_data",  -1, vd,       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rv = vecs[i].v; ra = vecs[i].a; rbe = vecs[i].be; rd = vecs[i].d;
      vr = vecs[i].vr; qa = vecs[i].qa;
      #2;
      chk("ready", i, 64'(rdy), 64'(vecs[i].rdy));
      chk("vrf_we", i, 64'(we), 64'(vecs[i].we));
      chk("vrf_addr", i, 64'(va), 64'(vecs[i].va));
      chk("vrf_bweb", i, 64'(vbe), 64'(vecs[i].vbe));
      chk("vrf_data", i, vd, vecs[i].vd);
      chk("count", i, 64'(cnt), 64'(vecs[i].cnt));
      chk("empty", i, 64'(emp), 64'(vecs[i].emp));
      chk("query_hit", i, 64'(hit), 64'(vecs[i].hit));
    end

    // Reset mid-stream discards queued writes
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rv = 1'b1; ra = 5'(10 + i); rbe = 8'hFF; rd = 64'(i); vr = 1'b0; qa = 5'd10;
    end
    @(negedge clk);
    idle_inputs();
    #2;
    chk("pre_rst_count", 100, 64'(cnt), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 100, 64'(cnt), 64'd0);
    chk("midrst_we",    100, 64'(we),  64'd0);
    chk("midrst_empty", 100, 64'(emp), 64'd1);
    chk("midrst_ready", 100, 64'(rdy), 64'd1);
    chk("midrst_hit",   100, 64'(hit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      chk("postrst_we", 101 + i, 64'(we), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vpu_wb_buffer.md
Name: vpu_wb_buffer

Overview:
- Write-back buffer directly downstream of the VPU lane wrapper.
- Accepts per-cycle lane results (register address, byte-enable, data) and queues them in a small FIFO.
- Drains to the vector register file (VRF) write port, which is shared and may be stalled by the load unit.
- Merges consecutive partial writes to the same vector register, and exposes a pending-write query for hazard checking by issue.

Parameters:
- VLEN, 64, vector register width in bits; must be a multiple of 8.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- result_valid_i  in  1  lane wrapper result valid.
- result_addr_i  in  5  destination vector register.
- result_bweb_i  in  VLEN/8  byte write-enable, 1 = write byte.
- result_data_i  in  VLEN  result data.
- ready_o  out  1  buffer can accept this cycle.
- vrf_we_o  out  1  VRF write request.
- vrf_addr_o  out  5  VRF write address.
- vrf_bweb_o  out  VLEN/8  VRF byte enable.
- vrf_data_o  out  VLEN  VRF write data.
- vrf_ready_i  in  1  VRF port granted this cycle.
- query_addr_i  in  5  register to check for pending writes.
- query_hit_o  out  1  a stored entry targets query_addr_i.
- count_o  out  $clog2(DEPTH+1)  occupied entries.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage: DEPTH entries {valid, addr, bweb, data}, a head and a tail pointer, and a count register. Pointers wrap modulo DEPTH.
- Reset (asynchronous, rst_ni=0): all entries invalid; pointers and count = 0; vrf_we_o=0; vrf_addr_o/bweb_o/data_o = 0; query_hit_o=0; ready_o=1; empty_o=1. Reset asserted mid-operation discards all queued writes.
- Accept: push = result_valid_i && ready_o.
- ready_o = (count < DEPTH) || merge_ok. It depends only on registered state and the current input, never on vrf_ready_i.
- Zero-byte write: result_valid_i with result_bweb_i == 0 is accepted and dropped. No entry is created and there is no state change.
- merge_ok: count > 0, the youngest entry's addr == result_addr_i, and the youngest entry is not the head being popped this cycle (i.e. not count==1 with a pop in progress).
- On merge:
  - for each byte b with result_bweb_i[b]=1, entry.data byte b <= input byte b;
  - entry.bweb <= entry.bweb | result_bweb_i;
  - count is unchanged.
- Otherwise a push writes a new entry at tail, tail++, count++.
- Drain: vrf_we_o = head valid. vrf_addr_o/bweb_o/data_o come straight from head entry registers, with no combinational path from result_*. All are 0 when empty.
- Pop = vrf_we_o && vrf_ready_i: head invalidated, head++, count--.
- Simultaneous push and pop: count stays the same.
- Latency: a result accepted at edge N is on vrf_* during cycle N+1 at the earliest (buffer empty). Sustained throughput is 1 write/cycle.
- Full (count==DEPTH) and no merge: ready_o=0, even if a pop occurs that cycle.
- Ordering: entries drain strictly in FIFO order. A merge never reorders: it only ever targets the youngest entry.
- query_hit_o: combinational OR over stored valid entries of (addr == query_addr_i). In-flight input is excluded.
- count_o and empty_o reflect registered state.

Optional Feature:
- Macro: VPU_WB_COALESCE_EN.
- Defined: merging behaves as above.
- Undefined: merge_ok is tied to 0. Every non-zero-byte push allocates its own entry, and ready_o = (count < DEPTH). All other behaviour is identical.

Test Plan:
- Reset mid-stream: push 3 entries, pull rst_ni low for 1 cycle -> count_o=0, vrf_we_o=0, empty_o=1, ready_o=1; no queued write ever appears.
- Single write, VRF ready: addr=5, bweb=0x0F, data=0x11223344_55667788 at edge N -> at N+1 vrf_we_o=1, addr 5, bweb 0x0F, data matches; after the pop, empty_o=1.
- Coalesce (macro on), vrf_ready_i=0: addr=3 bweb=0x03 data=..AAAA, then addr=3 bweb=0x0C data=..BBBB0000 -> count_o=1; head bweb=0x0F, data low 32 bits=0xBBBBAAAA. With macro off -> count_o=2.
- Full backpressure: vrf_ready_i=0, push DEPTH=4 distinct addrs 0..3 -> ready_o=0. A push to addr 3 is still accepted (merge, macro on); a push to addr 9 is not accepted. Raise vrf_ready_i -> writes drain in order 0,1,2,3.
- Pop/merge race: count=1, head addr=7 popping this cycle, new result to addr 7 -> new entry allocated, count stays 1, and two separate VRF writes to 7 occur.
- Query and zero-byte: entries at addrs 2 and 6; query_addr_i=6 -> query_hit_o=1, query_addr_i=4 -> 0. A result with bweb=0x00 -> accepted, count_o unchanged.
